// File: rtl/sha2_kt_sequencer.sv
// Registered SHA-2 round-constant sequencer.
// Steps through the SHA-224/256 (64 x 32-bit) or SHA-384/512 (80 x 64-bit)
// Kt table under a start/advance handshake. Kt comes straight from a flop;
// the ROM is addressed by the index the counter moves to on the next edge.
module sha2_kt_sequencer #(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              adv,
   input  logic              abort,
   output logic [WORD_W-1:0] kt,
   output logic              kt_valid,
   output logic [6:0]        rnd_idx,
   output logic              last,
   output logic              busy,
   output logic              done
);

   localparam int NUM_RND = (WORD_W == 64) ? 80 : 64;
   localparam logic [6:0] LAST_IDX = 7'(NUM_RND - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]        state_reg, state_next;
   logic [6:0]        idx_reg, idx_next;
   logic [WORD_W-1:0] kt_reg, kt_next;
   logic              load_k;
   logic [WORD_W-1:0] rom_word;

   // SHA-224/256 constants: first 32 bits of the fractional parts of the
   // cube roots of the first 64 primes.
   function automatic logic [31:0] k256(input logic [6:0] i);
      case (i)
         7'd0:  return 32'h428a2f98;  7'd1:  return 32'h71374491;
         7'd2:  return 32'hb5c0fbcf;  7'd3:  return 32'he9b5dba5;
         7'd4:  return 32'h3956c25b;  7'd5:  return 32'h59f111f1;
         7'd6:  return 32'h923f82a4;  7'd7:  return 32'hab1c5ed5;
         7'd8:  return 32'hd807aa98;  7'd9:  return 32'h12835b01;
         7'd10: return 32'h243185be;  7'd11: return 32'h550c7dc3;
         7'd12: return 32'h72be5d74;  7'd13: return 32'h80deb1fe;
         7'd14: return 32'h9bdc06a7;  7'd15: return 32'hc19bf174;
         7'd16: return 32'he49b69c1;  7'd17: return 32'hefbe4786;
         7'd18: return 32'h0fc19dc6;  7'd19: return 32'h240ca1cc;
         7'd20: return 32'h2de92c6f;  7'd21: return 32'h4a7484aa;
         7'd22: return 32'h5cb0a9dc;  7'd23: return 32'h76f988da;
         7'd24: return 32'h983e5152;  7'd25: return 32'ha831c66d;
         7'd26: return 32'hb00327c8;  7'd27: return 32'hbf597fc7;
         7'd28: return 32'hc6e00bf3;  7'd29: return 32'hd5a79147;
         7'd30: return 32'h06ca6351;  7'd31: return 32'h14292967;
         7'd32: return 32'h27b70a85;  7'd33: return 32'h2e1b2138;
         7'd34: return 32'h4d2c6dfc;  7'd35: return 32'h53380d13;
         7'd36: return 32'h650a7354;  7'd37: return 32'h766a0abb;
         7'd38: return 32'h81c2c92e;  7'd39: return 32'h92722c85;
         7'd40: return 32'ha2bfe8a1;  7'd41: return 32'ha81a664b;
         7'd42: return 32'hc24b8b70;  7'd43: return 32'hc76c51a3;
         7'd44: return 32'hd192e819;  7'd45: return 32'hd6990624;
         7'd46: return 32'hf40e3585;  7'd47: return 32'h106aa070;
         7'd48: return 32'h19a4c116;  7'd49: return 32'h1e376c08;
         7'd50: return 32'h2748774c;  7'd51: return 32'h34b0bcb5;
         7'd52: return 32'h391c0cb3;  7'd53: return 32'h4ed8aa4a;
         7'd54: return 32'h5b9cca4f;  7'd55: return 32'h682e6ff3;
         7'd56: return 32'h748f82ee;  7'd57: return 32'h78a5636f;
         7'd58: return 32'h84c87814;  7'd59: return 32'h8cc70208;
         7'd60: return 32'h90befffa;  7'd61: return 32'ha4506ceb;
         7'd62: return 32'hbef9a3f7;  7'd63: return 32'hc67178f2;
         default: return 32'h0;
      endcase
   endfunction

   // SHA-384/512 constants: first 64 bits of the fractional parts of the
   // cube roots of the first 80 primes.
   function automatic logic [63:0] k512(input logic [6:0] i);
      case (i)
         7'd0:  return 64'h428a2f98d728ae22;  7'd1:  return 64'h7137449123ef65cd;
         7'd2:  return 64'hb5c0fbcfec4d3b2f;  7'd3:  return 64'he9b5dba58189dbbc;
         7'd4:  return 64'h3956c25bf348b538;  7'd5:  return 64'h59f111f1b605d019;
         7'd6:  return 64'h923f82a4af194f9b;  7'd7:  return 64'hab1c5ed5da6d8118;
         7'd8:  return 64'hd807aa98a3030242;  7'd9:  return 64'h12835b0145706fbe;
         7'd10: return 64'h243185be4ee4b28c;  7'd11: return 64'h550c7dc3d5ffb4e2;
         7'd12: return 64'h72be5d74f27b896f;  7'd13: return 64'h80deb1fe3b1696b1;
         7'd14: return 64'h9bdc06a725c71235;  7'd15: return 64'hc19bf174cf692694;
         7'd16: return 64'he49b69c19ef14ad2;  7'd17: return 64'hefbe4786384f25e3;
         7'd18: return 64'h0fc19dc68b8cd5b5;  7'd19: return 64'h240ca1cc77ac9c65;
         7'd20: return 64'h2de92c6f592b0275;  7'd21: return 64'h4a7484aa6ea6e483;
         7'd22: return 64'h5cb0a9dcbd41fbd4;  7'd23: return 64'h76f988da831153b5;
         7'd24: return 64'h983e5152ee66dfab;  7'd25: return 64'ha831c66d2db43210;
         7'd26: return 64'hb00327c898fb213f;  7'd27: return 64'hbf597fc7beef0ee4;
         7'd28: return 64'hc6e00bf33da88fc2;  7'd29: return 64'hd5a79147930aa725;
         7'd30: return 64'h06ca6351e003826f;  7'd31: return 64'h142929670a0e6e70;
         7'd32: return 64'h27b70a8546d22ffc;  7'd33: return 64'h2e1b21385c26c926;
         7'd34: return 64'h4d2c6dfc5ac42aed;  7'd35: return 64'h53380d139d95b3df;
         7'd36: return 64'h650a73548baf63de;  7'd37: return 64'h766a0abb3c77b2a8;
         7'd38: return 64'h81c2c92e47edaee6;  7'd39: return 64'h92722c851482353b;
         7'd40: return 64'ha2bfe8a14cf10364;  7'd41: return 64'ha81a664bbc423001;
         7'd42: return 64'hc24b8b70d0f89791;  7'd43: return 64'hc76c51a30654be30;
         7'd44: return 64'hd192e819d6ef5218;  7'd45: return 64'hd69906245565a910;
         7'd46: return 64'hf40e35855771202a;  7'd47: return 64'h106aa07032bbd1b8;
         7'd48: return 64'h19a4c116b8d2d0c8;  7'd49: return 64'h1e376c085141ab53;
         7'd50: return 64'h2748774cdf8eeb99;  7'd51: return 64'h34b0bcb5e19b48a8;
         7'd52: return 64'h391c0cb3c5c95a63;  7'd53: return 64'h4ed8aa4ae3418acb;
         7'd54: return 64'h5b9cca4f7763e373;  7'd55: return 64'h682e6ff3d6b2b8a3;
         7'd56: return 64'h748f82ee5defb2fc;  7'd57: return 64'h78a5636f43172f60;
         7'd58: return 64'h84c87814a1f0ab72;  7'd59: return 64'h8cc702081a6439ec;
         7'd60: return 64'h90befffa23631e28;  7'd61: return 64'ha4506cebde82bde9;
         7'd62: return 64'hbef9a3f7b2c67915;  7'd63: return 64'hc67178f2e372532b;
         7'd64: return 64'hca273eceea26619c;  7'd65: return 64'hd186b8c721c0c207;
         7'd66: return 64'heada7dd6cde0eb1e;  7'd67: return 64'hf57d4f7fee6ed178;
         7'd68: return 64'h06f067aa72176fba;  7'd69: return 64'h0a637dc5a2c898a6;
         7'd70: return 64'h113f9804bef90dae;  7'd71: return 64'h1b710b35131c471b;
         7'd72: return 64'h28db77f523047d84;  7'd73: return 64'h32caab7b40c72493;
         7'd74: return 64'h3c9ebe0a15c9bebc;  7'd75: return 64'h431d67c49c100d4c;
         7'd76: return 64'h4cc5d4becb3e42b6;  7'd77: return 64'h597f299cfc657e2a;
         7'd78: return 64'h5fcb6fab3ad6faec;  7'd79: return 64'h6c44198c4a475817;
         default: return 64'h0;
      endcase
   endfunction

   // Only the two SHA-2 word sizes have a constant table.
   generate
      if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
         $error("sha2_kt_sequencer: WORD_W must be 32 or 64");
      end
   endgenerate

   // Pick the table for this word size; it is looked up at the next index.
   generate
      if (WORD_W == 64) begin : g_rom512
         assign rom_word = k512(idx_next);
      end else begin : g_rom256
         assign rom_word = k256(idx_next);
      end
   endgenerate

   // Next state and next round index; abort overrides start and adv.
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      load_k     = 1'b0;
      if (abort) begin
         state_next = IDLE;
         idx_next   = 7'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_next = RUN;
                  idx_next   = 7'd0;
                  load_k     = 1'b1;
               end
            end
            RUN: begin
               if (adv) begin
                  if (idx_reg == LAST_IDX) begin
                     state_next = DONE;
                     idx_next   = 7'd0;
                  end else begin
                     idx_next = idx_reg + 7'd1;
                     load_k   = 1'b1;
                  end
               end
            end
            DONE: begin
               idx_next = 7'd0;
               if (start) begin
                  state_next = RUN;
                  load_k     = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
               idx_next   = 7'd0;
            end
         endcase
      end
   end

   // Kt loads a new constant, holds during a stall, or clears outside RUN.
   always_comb begin
      kt_next = kt_reg;
      if (load_k) begin
         kt_next = rom_word;
      end else if (state_next != RUN) begin
         kt_next = '0;
      end
   end

   // State, index and constant registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= 7'd0;
         kt_reg    <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         kt_reg    <= kt_next;
      end
   end

   assign kt       = kt_reg;
   assign rnd_idx  = idx_reg;
   assign kt_valid = (state_reg == RUN);
   assign busy     = (state_reg == RUN);
   assign last     = (state_reg == RUN) && (idx_reg == LAST_IDX);
   assign done     = (state_reg == DONE);

endmodule
